muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 16 +
 rtl/muldiv_decode.sv | 22 ++
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: opcode encodings,
// default timeout and the sequencer state encoding.
package muldiv_sequencer_pkg;

    localparam logic [4:0] PKG_OPC_ALU = 5'b00000;
    localparam logic [4:0] PKG_OP_MULT = 5'b00110;
    localparam logic [4:0] PKG_OP_DIV  = 5'b00111;
    localparam int         PKG_MAX_LAT = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational decode of ALU-class multiply/divide instructions.
module muldiv_decode
    import muldiv_sequencer_pkg::*;
#(
    parameter logic [4:0] OPC_ALU = PKG_OPC_ALU,
    parameter logic [4:0] OP_MULT = PKG_OP_MULT,
    parameter logic [4:0] OP_DIV  = PKG_OP_DIV
) (
    input  logic [31:0] ir,
    output logic        hit,
    output logic        is_div
);

    logic unused_ir_bits;

    assign is_div = (ir[6:2] == OP_DIV);
    assign hit    = (ir[31:27] == OPC_ALU) && ((ir[6:2] == OP_MULT) || is_div);

    // Only the opcode and ALU-op fields take part in the decode.
    assign unused_ir_bits = ^{ir[26:7], ir[1:0]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues start pulses to an external multdiv unit, stalls the pipeline while it
// runs and reports completion, exception or timeout with the latched rd tag.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter logic [4:0] OPC_ALU = PKG_OPC_ALU,
    parameter logic [4:0] OP_MULT = PKG_OP_MULT,
    parameter logic [4:0] OP_DIV  = PKG_OP_DIV,
    parameter int         MAX_LAT = PKG_MAX_LAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [31:0] ir,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    output logic        ctrl_Mult,
    output logic        ctrl_Div,
    output logic        stall,
    output logic        done,
    output logic        is_div,
    output logic [4:0]  rd_tag,
    output logic        exc,
    output logic        timeout
);

    localparam logic [7:0] CNT_SAT  = 8'(MAX_LAT);
    localparam logic [7:0] CNT_LAST = 8'(MAX_LAT - 1);

    seq_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_div_q, is_div_d;
    logic [4:0] rd_tag_q, rd_tag_d;
    logic       exc_q, exc_d;
    logic       timeout_q, timeout_d;

    logic dec_hit;
    logic dec_is_div;
    logic accept;
    logic first_run;

    muldiv_decode #(
        .OPC_ALU (OPC_ALU),
        .OP_MULT (OP_MULT),
        .OP_DIV  (OP_DIV)
    ) u_decode (
        .ir     (ir),
        .hit    (dec_hit),
        .is_div (dec_is_div)
    );

    assign accept = ir_valid && dec_hit && !flush;
    // The counter is cleared at accept, so zero marks the start-pulse cycle.
    assign first_run = (state_q == ST_RUN) && (cnt_q == 8'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        rd_tag_d  = rd_tag_q;
        exc_d     = exc_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d   = ST_RUN;
                    cnt_d     = 8'd0;
                    is_div_d  = dec_is_div;
                    rd_tag_d  = ir[26:22];
                    exc_d     = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // A real result beats a coincident timeout.
                    if (data_resultRDY && !first_run) begin
                        state_d   = ST_DONE;
                        exc_d     = data_exception;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_DONE;
                        exc_d     = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            is_div_q  <= 1'b0;
            rd_tag_q  <= 5'd0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            rd_tag_q  <= rd_tag_d;
            exc_q     <= exc_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall     = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign ctrl_Mult = first_run && !is_div_q;
    assign ctrl_Div  = first_run && is_div_q;
    assign is_div    = is_div_q;
    assign rd_tag    = rd_tag_q;
    assign exc       = exc_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scenarios for muldiv_sequencer; completions are checked against a
// scoreboard of expected {is_div, rd_tag, exc, timeout} pushed at accept.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ir_valid = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        flush = 1'b0;
    logic        data_resultRDY = 1'b0;
    logic        data_exception = 1'b0;
    logic        ctrl_Mult, ctrl_Div, stall, done, is_div, exc, timeout;
    logic [4:0]  rd_tag;
    logic [11:0] outs;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       is_div;
        logic [4:0] rd;
        logic       exc;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    muldiv_sequencer #(.MAX_LAT(10)) dut (
        .clock          (clock),
        .reset          (reset),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .flush          (flush),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .ctrl_Mult      (ctrl_Mult),
        .ctrl_Div       (ctrl_Div),
        .stall          (stall),
        .done           (done),
        .is_div         (is_div),
        .rd_tag         (rd_tag),
        .exc            (exc),
        .timeout        (timeout)
    );

    assign outs = {ctrl_Mult, ctrl_Div, stall, done, is_div, rd_tag, exc, timeout};

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(logic [4:0] opc, logic [4:0] rd, logic [4:0] op);
        return {opc, rd, 15'd0, op, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd7, 5'd6);
        tick();
        tick();
        vectors++;
        if (outs !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", outs, 12'd0);
        end
        ir_valid = 1'b0;
        ir = 32'd0;
        reset = 1'b1;
        tick();
        vectors++;
        if (outs !== 12'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want %b", outs, 12'd0);
        end
    endtask

    task automatic test_mult();
        int stall_cnt = 0;
        int mult_cnt = 0;
        int div_cnt = 0;
        exp_t e;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd7, 5'd6);
        sb.push_back('{is_div: 1'b0, rd: 5'd7, exc: 1'b0, tmo: 1'b0});
        tick();
        ir_valid = 1'b0;
        vectors++;
        if ({ctrl_Mult, ctrl_Div} !== 2'b10) begin
            miscompares++;
            $display("FAIL mult_first_pulse: got %b want 10", {ctrl_Mult, ctrl_Div});
        end
        for (int k = 1; k <= 6; k++) begin
            stall_cnt += int'(stall);
            mult_cnt += int'(ctrl_Mult);
            div_cnt += int'(ctrl_Div);
            if (k == 6) data_resultRDY = 1'b1;
            tick();
        end
        data_resultRDY = 1'b0;
        vectors++;
        if (stall_cnt != 6 || mult_cnt != 1 || div_cnt != 0) begin
            miscompares++;
            $display("FAIL mult_counts: stall=%0d mult=%0d div=%0d want 6 1 0", stall_cnt, mult_cnt, div_cnt);
        end
        vectors++;
        if ({done, stall} !== 2'b10) begin
            miscompares++;
            $display("FAIL mult_done: got done,stall=%b want 10", {done, stall});
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL mult_result: scoreboard empty at done");
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL mult_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        tick();
        vectors++;
        if ({done, stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL mult_idle_after: got done,stall=%b want 00", {done, stall});
        end
    endtask

    task automatic test_div_exception();
        exp_t e;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd3, 5'd7);
        sb.push_back('{is_div: 1'b1, rd: 5'd3, exc: 1'b1, tmo: 1'b0});
        tick();
        ir_valid = 1'b0;
        vectors++;
        if ({ctrl_Mult, ctrl_Div} !== 2'b01) begin
            miscompares++;
            $display("FAIL div_first_pulse: got %b want 01", {ctrl_Mult, ctrl_Div});
        end
        // Result-ready during the start-pulse cycle must be ignored.
        data_resultRDY = 1'b1;
        data_exception = 1'b1;
        tick();
        vectors++;
        if ({stall, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL div_rdy_first_ignored: got stall,done=%b want 10", {stall, done});
        end
        tick();
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        vectors++;
        if (sb.size() == 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL div_done: got done=%b queue=%0d want done=1", done, sb.size());
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL div_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int run = 0;
        exp_t e;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd12, 5'd6);
        sb.push_back('{is_div: 1'b0, rd: 5'd12, exc: 1'b0, tmo: 1'b1});
        tick();
        ir_valid = 1'b0;
        while (stall === 1'b1 && run < 30) begin
            run++;
            tick();
        end
        vectors++;
        if (run != 10) begin
            miscompares++;
            $display("FAIL timeout_run_cycles: got %0d want 10", run);
        end
        vectors++;
        if (sb.size() == 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_done: got done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL timeout_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        tick();
        vectors++;
        if ({done, exc, timeout} !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_hold: got done,exc,timeout=%b want 001", {done, exc, timeout});
        end
    endtask

    task automatic test_flush();
        logic seen_done = 1'b0;
        logic seen_pulse = 1'b0;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd5, 5'd6);
        tick();
        ir_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_run3: got stall=%b want 1", stall);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if ({stall, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_abort: got stall,done=%b want 00", {stall, done});
        end
        for (int k = 0; k < 4; k++) begin
            data_resultRDY = (k == 0);
            seen_done |= done;
            seen_pulse |= ctrl_Mult | ctrl_Div;
            tick();
        end
        data_resultRDY = 1'b0;
        vectors++;
        if ({seen_done, seen_pulse} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_quiet: got done,pulse seen=%b want 00", {seen_done, seen_pulse});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd9, 5'd7);
        sb.push_back('{is_div: 1'b1, rd: 5'd9, exc: 1'b0, tmo: 1'b0});
        tick();
        ir_valid = 1'b0;
        tick();
        data_resultRDY = 1'b1;
        tick();
        data_resultRDY = 1'b0;
        vectors++;
        if (sb.size() == 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_div_done: got done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL b2b_div_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd10, 5'd6);
        sb.push_back('{is_div: 1'b0, rd: 5'd10, exc: 1'b0, tmo: 1'b0});
        tick();
        ir_valid = 1'b0;
        vectors++;
        if ({ctrl_Mult, ctrl_Div, stall, done, is_div, rd_tag} !== {5'b10100, 5'd10}) begin
            miscompares++;
            $display("FAIL b2b_second_start: got %b want %b", {ctrl_Mult, ctrl_Div, stall, done, is_div, rd_tag}, {5'b10100, 5'd10});
        end
        tick();
        data_resultRDY = 1'b1;
        tick();
        data_resultRDY = 1'b0;
        vectors++;
        if (sb.size() == 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_mult_done: got done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL b2b_mult_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        // Flush while in DONE: the done pulse stands but the new accept is blocked.
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd11, 5'd7);
        flush = 1'b1;
        tick();
        ir_valid = 1'b0;
        flush = 1'b0;
        vectors++;
        if ({stall, done, ctrl_Div, rd_tag} !== {3'b000, 5'd10}) begin
            miscompares++;
            $display("FAIL done_flush_block: got %b want %b", {stall, done, ctrl_Div, rd_tag}, {3'b000, 5'd10});
        end
    endtask

    task automatic test_reset_mid_run();
        logic any_pulse = 1'b0;
        logic any_out = 1'b0;
        exp_t e;
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd17, 5'd7);
        tick();
        ir_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (outs !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_async_abort: got %b want %b", outs, 12'd0);
        end
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd17, 5'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            any_pulse |= ctrl_Mult | ctrl_Div;
            any_out |= (outs != 12'd0);
        end
        ir_valid = 1'b0;
        vectors++;
        if ({any_pulse, any_out} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_nonhit_quiet: got pulse,out=%b want 00", {any_pulse, any_out});
        end
        ir_valid = 1'b1;
        ir = mk_ir(5'd0, 5'd1, 5'd6);
        sb.push_back('{is_div: 1'b0, rd: 5'd1, exc: 1'b0, tmo: 1'b0});
        tick();
        ir_valid = 1'b0;
        vectors++;
        if ({ctrl_Mult, ctrl_Div, stall} !== 3'b101) begin
            miscompares++;
            $display("FAIL post_reset_start: got %b want 101", {ctrl_Mult, ctrl_Div, stall});
        end
        tick();
        data_resultRDY = 1'b1;
        tick();
        data_resultRDY = 1'b0;
        vectors++;
        if (sb.size() == 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_done: got done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            if ({is_div, rd_tag, exc, timeout} !== e) begin
                miscompares++;
                $display("FAIL post_reset_result: got %b want %b", {is_div, rd_tag, exc, timeout}, e);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_exception();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
